// File: rtl/fifo_ctrl.sv
// ---------------------------------------------------------------------------
// fifo_ctrl -- single-clock FIFO sequencer for a dual-port RAM with a
// registered (1-cycle) read port.
//
// Owns the write/read pointers, the full/empty flags and the occupancy. It
// drives the RAM write/read controls and presents a first-word-fall-through
// valid/ready stream. The head word is the RAM's rdata, which holds while
// rclken is low, so this block never stores data.
//
// Parameters:
//   ASIZE        RAM address bits (DEPTH = 2**ASIZE)
//   AFULL_LEVEL  level at or above which almost_full asserts (1..DEPTH+1)
//
// Ports:
//   clk, rstn              clock, async active-low reset
//   i_valid / i_ready      write side handshake
//   o_valid / o_ready      read side handshake (data = RAM rdata)
//   ram_wclken/waddr/wfull RAM write port controls
//   ram_rclken/raddr       RAM read port controls
//   level                  words held (RAM + output word), 0..DEPTH+1
//   almost_full            registered, level >= AFULL_LEVEL
//   i_clear                synchronous flush, only with FIFO_CTRL_CLEAR_EN
//
// Optional feature macro: FIFO_CTRL_CLEAR_EN
// ---------------------------------------------------------------------------
module fifo_ctrl #(
    parameter int ASIZE       = 4,
    parameter int AFULL_LEVEL = 14
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             i_valid,
    output logic             i_ready,
    output logic             o_valid,
    input  logic             o_ready,
`ifdef FIFO_CTRL_CLEAR_EN
    input  logic             i_clear,
`endif
    output logic             ram_wclken,
    output logic [ASIZE-1:0] ram_waddr,
    output logic             ram_wfull,
    output logic             ram_rclken,
    output logic [ASIZE-1:0] ram_raddr,
    output logic [ASIZE:0]   level,
    output logic             almost_full
);

    localparam logic [ASIZE:0] AFULL_THR = (ASIZE+1)'(AFULL_LEVEL);

    logic [ASIZE:0] wptr_q, wptr_d;
    logic [ASIZE:0] rptr_q, rptr_d;
    logic           o_valid_q, o_valid_d;
    logic [ASIZE:0] level_q, level_d;
    logic           almost_full_q, almost_full_d;

    logic           clear;
    logic           full;
    logic           ram_empty;
    logic           wr;
    logic           rd;

`ifdef FIFO_CTRL_CLEAR_EN
    assign clear = i_clear;
`else
    assign clear = 1'b0;
`endif

    always_comb begin
        // Extra pointer bit distinguishes full from empty when the
        // address bits match.
        full      = (wptr_q[ASIZE] != rptr_q[ASIZE]) &&
                    (wptr_q[ASIZE-1:0] == rptr_q[ASIZE-1:0]);
        ram_empty = (wptr_q == rptr_q);

        // Flush beats any write, read issue or pop in the same cycle.
        wr = i_valid && !full && !clear;
        // Issue a read when the output slot is empty or being consumed.
        // Uses current pointers only: a word written this cycle is not
        // readable until the next one.
        rd = !ram_empty && (!o_valid_q || o_ready) && !clear;

        wptr_d = wptr_q + {{ASIZE{1'b0}}, wr};
        rptr_d = rptr_q + {{ASIZE{1'b0}}, rd};

        o_valid_d = o_valid_q;
        if (rd)
            o_valid_d = 1'b1;
        else if (o_valid_q && o_ready)
            o_valid_d = 1'b0;

        if (clear) begin
            wptr_d    = '0;
            rptr_d    = '0;
            o_valid_d = 1'b0;
        end

        // Occupancy counts the word parked on the RAM output as well.
        level_d       = (wptr_d - rptr_d) + {{ASIZE{1'b0}}, o_valid_d};
        almost_full_d = (level_d >= AFULL_THR);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q        <= '0;
            rptr_q        <= '0;
            o_valid_q     <= 1'b0;
            level_q       <= '0;
            almost_full_q <= 1'b0;
        end else begin
            wptr_q        <= wptr_d;
            rptr_q        <= rptr_d;
            o_valid_q     <= o_valid_d;
            level_q       <= level_d;
            almost_full_q <= almost_full_d;
        end
    end

    assign i_ready     = !full;
    assign o_valid     = o_valid_q;
    assign ram_wclken  = wr;
    assign ram_waddr   = wptr_q[ASIZE-1:0];
    assign ram_wfull   = full;
    assign ram_rclken  = rd;
    assign ram_raddr   = rptr_q[ASIZE-1:0];
    assign level       = level_q;
    assign almost_full = almost_full_q;

endmodule
